imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory of the pipelined CPU. It takes a byte stream from a host link over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the write port of the instruction memory at word-aligned byte addresses, so that a fetch reading `pc>>2` sees them. Locations past the loaded program are zero-filled, which makes them decode as NOPs. `cpu_hold` stays asserted for the whole load so the CPU cannot fetch a partially written program.

## Interface
Parameters:
- `DEPTH`, 128: instruction memory size in 32-bit words.
- `AW`, 7: word-index width; must satisfy 2^AW = DEPTH.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- `load_len`  in  AW+1  number of words to load; sampled on the `start` cycle.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  8  host byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  instruction memory write strobe.
- `wr_addr`  out  32  byte address, always equal to word index << 2.
- `wr_data`  out  32  instruction word.
- `cpu_hold`  out  1  stall/reset request to the CPU while loading.
- `done`  out  1  level; load complete.
- `error`  out  1  level; checksum mismatch (configuration-dependent).

## Operation
States: IDLE, RECV, WRITE, FILL, CHECK, DONE.
- IDLE/DONE + `start`:
  - Latch `len = min(load_len, DEPTH)`; clear the word index, byte count, `done` and `error`.
  - Go to RECV if `len > 0`, otherwise go to FILL.
- RECV:
  - `in_ready` = 1.
  - Each handshake (`in_valid && in_ready`) shifts the byte into the assembly register MSB-first: the first byte received becomes bits [31:24].
  - The handshake that delivers byte 4 moves the FSM to WRITE.
- WRITE:
  - `in_ready` = 0.
  - `wr_en` = 1 for exactly one cycle, with `wr_addr` = index<<2 and `wr_data` = the assembled word.
  - Increment the index.
  - If the index was `len-1`: go to CHECK (macro defined) or FILL (macro undefined). Otherwise return to RECV.
- FILL:
  - One zero write per cycle (`wr_en`=1, `wr_data`=0) at the current index, incrementing it.
  - The write at index DEPTH-1 is the last one; then go to DONE.
  - If `len == DEPTH`, FILL is skipped and the FSM goes straight to DONE or CHECK.
- DONE: `done` = 1 and `cpu_hold` = 0; remains until `start` or `reset`.
- `cpu_hold` = 1 in RECV, WRITE, FILL and CHECK; 0 in IDLE and DONE.
- `in_ready` = 1 only in RECV and CHECK.
- The word index is AW+1 bits, so it never wraps: loads longer than DEPTH are clamped, and excess host bytes are never accepted.
- `start` during a busy state is ignored and has no side effects.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready`, `wr_en`, `cpu_hold`, `done` and `error` are 0.
  - `wr_addr`, `wr_data`, the index, the byte count and the checksum are 0.
- All outputs are registered or decoded from the state register; there is no combinational path from `in_valid` to any output.
- The write occurs in the cycle after the 4th-byte handshake. With `in_valid` held high, a word costs 5 cycles: 4 RECV plus 1 WRITE.
- Gaps on `in_valid` stall RECV indefinitely with no timeout, and partial bytes are retained.
- FILL takes DEPTH-len cycles.
- `reset` asserted mid-load aborts immediately: the next cycle is IDLE with the reset values above. Words already written stay in memory.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Every accepted byte is XORed into an 8-bit checksum.
  - After the last word, CHECK accepts one further byte.
  - If that byte differs from the checksum, `error` is set and the FSM goes to DONE without FILL. Otherwise the FSM goes to FILL.
  - `error` holds until the next `start` or `reset`.
- Undefined:
  - No CHECK state and no checksum byte.
  - `error` is tied to 0.

## Test plan
- 2-word load, bytes 20 08 00 20 20 09 00 37 with `in_valid` held high:
  - Writes (addr 0, 0x20080020) and (addr 4, 0x20090037).
  - Then 126 zero writes at addresses 8..508.
  - `done`=1 and `cpu_hold`=0 afterwards.
- The same load with `in_valid` low for 3 cycles between every byte: identical write sequence; `wr_en` is never asserted during gaps.
- `load_len`=0: 128 zero writes at addresses 0..508 on consecutive cycles; `in_ready` never asserted.
- `load_len`=200: exactly 128 data writes, no FILL, and the 513th byte is not accepted (`in_ready`=0).
- `reset` pulsed after the 2nd byte of word 1:
  - Next cycle is IDLE with all outputs 0.
  - A new `start` with `len`=1 and bytes AC 10 00 04 writes 0xAC100004 at addr 0.
- With `IMEM_LOADER_CHECKSUM_EN`:
  - Bytes 20 08 00 20 followed by checksum 0x08 → `error`=0, FILL runs.
  - The same bytes followed by checksum 0x09 → `error`=1, DONE with no zero writes.

Source files
------------

// File: rtl/imem_loader_if.sv
// Host byte stream (valid/ready) and instruction-memory write port of imem_loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: big-endian byte stream -> word writes, zero fill after program.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   load_len,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_FILL,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_t      state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [AW:0] len_clamp;
  state_t      after_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign len_clamp = (load_len > DEPTH_W) ? DEPTH_W : load_len;

  // Destination once the last program word is written; a full-depth load has nothing to fill.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign after_data = S_CHECK;
`else
  assign after_data = (len_q == DEPTH_W) ? S_DONE : S_FILL;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d   = len_clamp;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
          state_d = (len_clamp != '0) ? S_RECV : S_FILL;
        end
      end
      S_RECV: begin
        if (bus.in_valid) begin
          word_d = {word_q[23:0], bus.in_data};
          cnt_d  = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          if (cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + ONE;
        state_d = (idx_q == len_q - ONE) ? after_data : S_RECV;
      end
      S_FILL: begin
        idx_d = idx_q + ONE;
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (bus.in_valid) begin
          if (bus.in_data != csum_q) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = (len_q == DEPTH_W) ? S_DONE : S_FILL;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.in_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign error        = err_q;
`else
  assign bus.in_ready = (state_q == S_RECV);
  assign error        = 1'b0;
`endif
  assign bus.wr_en   = (state_q == S_WRITE) || (state_q == S_FILL);
  assign bus.wr_addr = 32'(idx_q) << 2;
  assign bus.wr_data = (state_q == S_WRITE) ? word_q : '0;
  assign cpu_hold    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven random loads vs. a memory-image model, plus hand sequences.
module tb_imem_loader;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int L;
    int gap;
    bit busy;
    int nd;
    int nf;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   load_len;
  logic          cpu_hold, done, error;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .bus(bus), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          cyc = 0;
  int          ready_cnt = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.wr_en) begin
      log_addr.push_back(bus.wr_addr);
      log_data.push_back(bus.wr_data);
      log_cyc.push_back(cyc);
    end
    if (bus.in_ready) ready_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input byte_q_t b, input int i);
    return 32'(b[4*i]) * 32'h0100_0000 + 32'(b[4*i+1]) * 32'h0001_0000 +
           32'(b[4*i+2]) * 32'h0000_0100 + 32'(b[4*i+3]);
  endfunction

  // Presents one byte and waits (bounded) until the handshake edge has passed.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 200; n++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input int L, input byte_q_t bytes, input int gap,
                          input bit busy, input bit bad_csum, input int exp_nd, input int exp_nf,
                          input bit exp_err);
    int          len_eff;
    int          nd, total, w;
    bit          ok, model_err;
    logic [7:0]  csum;
    logic [31:0] exp_d;
    len_eff   = (L > DEPTH) ? DEPTH : L;
    model_err = 1'b0;
    csum      = 8'h00;
    for (int i = 0; i < len_eff * 4; i++) csum = csum ^ bytes[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (len_eff > 0 && bad_csum) model_err = 1'b1;
`endif
    nd    = len_eff;
    total = model_err ? nd : DEPTH;

    log_addr.delete(); log_data.delete(); log_cyc.delete();
    ready_cnt = 0;
    load_len  = (AW+1)'(L);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_hold_busy"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done_clear"}, 32'(done), 32'd0);

    for (int i = 0; i < len_eff * 4; i++) begin
      send_byte(bytes[i], ok);
      if (!ok) begin
        check({tag, "_byte_accept_timeout"}, 32'(i), 32'hFFFF_FFFF);
        break;
      end
      if (busy && i == 0) begin
        load_len = '0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      repeat (gap) @(negedge clk);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (len_eff > 0) begin
      send_byte(bad_csum ? (csum ^ 8'h01) : csum, ok);
      if (!ok) check({tag, "_csum_accept_timeout"}, 32'd0, 32'd1);
    end
`endif

    for (int n = 0; n < 400 && !done; n++) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_nwrites"}, 32'(log_addr.size()), 32'(exp_nd + exp_nf));

    w = (log_addr.size() < total) ? log_addr.size() : total;
    for (int i = 0; i < w; i++) begin
      exp_d = (i < nd) ? word_of(bytes, i) : 32'h0;
      check($sformatf("%s_addr%0d", tag, i), log_addr[i], 32'(i * 4));
      check($sformatf("%s_data%0d", tag, i), log_data[i], exp_d);
    end

    if (gap == 0 && !busy && log_addr.size() == total) begin
      for (int i = 1; i < nd; i++)
        check($sformatf("%s_wordgap%0d", tag, i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd5);
      for (int i = nd + 1; i < total; i++)
        check($sformatf("%s_fillgap%0d", tag, i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
    end
    if (len_eff == 0) check({tag, "_no_ready"}, 32'(ready_cnt), 32'd0);

    // Any surplus host byte must be refused once the load has finished.
    ready_cnt    = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_extra_refused"}, 32'(ready_cnt), 32'd0);
  endtask

  vec_t    tbl[8];
  byte_q_t bq;
  bit      ok;

  initial begin
    tbl[0] = '{L: 2,   gap: 0, busy: 1'b0, nd: 2,   nf: 126};
    tbl[1] = '{L: 2,   gap: 3, busy: 1'b0, nd: 2,   nf: 126};
    tbl[2] = '{L: 0,   gap: 0, busy: 1'b0, nd: 0,   nf: 128};
    tbl[3] = '{L: 200, gap: 0, busy: 1'b0, nd: 128, nf: 0};
    tbl[4] = '{L: 1,   gap: 1, busy: 1'b1, nd: 1,   nf: 127};
    tbl[5] = '{L: 128, gap: 0, busy: 1'b0, nd: 128, nf: 0};
    tbl[6] = '{L: 5,   gap: 2, busy: 1'b1, nd: 5,   nf: 123};
    tbl[7] = '{L: 127, gap: 0, busy: 1'b0, nd: 127, nf: 1};

    reset = 1'b1; start = 1'b0; load_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_wr_en",    32'(bus.wr_en),    32'd0);
    check("rst_wr_addr",  bus.wr_addr,       32'd0);
    check("rst_wr_data",  bus.wr_data,       32'd0);
    check("rst_cpu_hold", 32'(cpu_hold),     32'd0);
    check("rst_done",     32'(done),         32'd0);
    check("rst_error",    32'(error),        32'd0);
    reset = 1'b0;
    @(negedge clk);

    bq = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
    run_load("spec2", 2, bq, 0, 1'b0, 1'b0, 2, 126, 1'b0);
    run_load("spec2gap", 2, bq, 3, 1'b0, 1'b0, 2, 126, 1'b0);

    for (int t = 0; t < 8; t++) begin
      bq.delete();
      for (int i = 0; i < ((tbl[t].L > DEPTH) ? DEPTH : tbl[t].L) * 4; i++)
        bq.push_back(8'($urandom_range(0, 255)));
      run_load($sformatf("vec%0d", t), tbl[t].L, bq, tbl[t].gap, tbl[t].busy, 1'b0,
               tbl[t].nd, tbl[t].nf, 1'b0);
    end

    // Reset in the middle of a word: immediate abort, then a clean reload.
    load_len = (AW+1)'(2);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h11, ok);
    send_byte(8'h22, ok);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_wr_en",    32'(bus.wr_en),    32'd0);
    check("abort_wr_addr",  bus.wr_addr,       32'd0);
    check("abort_wr_data",  bus.wr_data,       32'd0);
    check("abort_cpu_hold", 32'(cpu_hold),     32'd0);
    check("abort_done",     32'(done),         32'd0);
    check("abort_error",    32'(error),        32'd0);
    bq = '{8'hAC, 8'h10, 8'h00, 8'h04};
    run_load("reload", 1, bq, 0, 1'b0, 1'b0, 1, 127, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    bq = '{8'h20, 8'h08, 8'h00, 8'h20};
    run_load("csum_ok",  1, bq, 0, 1'b0, 1'b0, 1, 127, 1'b0);
    run_load("csum_bad", 1, bq, 0, 1'b0, 1'b1, 1, 0,   1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
